// File: rtl/sector_hexdump.sv
// Raw byte stream to ASCII hex dump text, "OOOO: XX XX .. XX\r\n" per line.
// Latency: first char 2 cycles after a byte lands in an empty FIFO; up to 1 char/cycle.
// Backpressure: input has none (overflow drops bytes); output holds out_req/out_data until out_gnt.
module sector_hexdump #(
  parameter int FIFO_ASIZE     = 10,
  parameter int BYTES_PER_LINE = 16,
  parameter int UPPERCASE      = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       out_req,
  input  logic       out_gnt,
  output logic [7:0] out_data,
  output logic       overflow,
  output logic       busy
);

  localparam int LW = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
  typedef logic [LW-1:0] idx_t;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR3, S_ADDR2, S_ADDR1, S_ADDR0, S_COLON,
    S_SPC, S_HI, S_LO, S_SEP, S_CR, S_LF
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  out_data_q, out_data_d;
  logic [15:0] offset_q, offset_d;
  idx_t        line_idx_q, line_idx_d;
  logic        overflow_q, overflow_d;
  logic        abort_q, abort_d;

  logic        fifo_wr_vld;
  logic        fifo_rd_req;
  logic        fifo_pop;
  logic [7:0]  fifo_rd_dat;
  logic        fifo_empty;
  logic        fifo_full;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    logic [7:0] base;
    if (nib < 4'd10) base = 8'h30;
    else             base = (UPPERCASE != 0) ? 8'h37 : 8'h57;
    return base + {4'h0, nib};
  endfunction

  // The byte being formatted keeps its FIFO slot until its LO char is granted,
  // so the in-flight byte counts against the FIFO capacity.
  sync_fifo #(.ASIZE(FIFO_ASIZE), .WIDTH(8)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .wr_vld (fifo_wr_vld),
    .wr_dat (in_data),
    .rd_req (fifo_rd_req),
    .rd_pop (fifo_pop),
    .rd_dat (fifo_rd_dat),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  assign fifo_wr_vld = in_valid & ~clear;

  always_comb begin
    overflow_d = overflow_q;
    if (clear)                      overflow_d = 1'b0;
    else if (in_valid && fifo_full) overflow_d = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    line_idx_d  = line_idx_q;
    abort_d     = abort_q;
    fifo_rd_req = 1'b0;
    fifo_pop    = 1'b0;
    out_data_d  = out_data_q;

    if (clear) begin
      offset_d   = 16'h0000;
      line_idx_d = '0;
    end

    if (state_q == S_IDLE) begin
      abort_d = 1'b0;
      if (!fifo_empty && !clear) begin
        fifo_rd_req = 1'b1;
        state_d     = (line_idx_q == '0) ? S_ADDR3 : S_SEP;
      end
    end else if (clear || abort_q) begin
      // A cleared stream still owes its pending char; finish it, then idle.
      abort_d = ~out_gnt;
      if (out_gnt) state_d = S_IDLE;
    end else if (out_gnt) begin
      case (state_q)
        S_ADDR3: state_d = S_ADDR2;
        S_ADDR2: state_d = S_ADDR1;
        S_ADDR1: state_d = S_ADDR0;
        S_ADDR0: state_d = S_COLON;
        S_COLON: state_d = S_SPC;
        S_SPC:   state_d = S_HI;
        S_SEP:   state_d = S_HI;
        S_HI:    state_d = S_LO;
        S_LO: begin
          fifo_pop = 1'b1;
          offset_d = offset_q + 16'd1;
          if (line_idx_q == idx_t'(BYTES_PER_LINE - 1)) begin
            line_idx_d = '0;
            state_d    = S_CR;
          end else begin
            line_idx_d = line_idx_q + idx_t'(1);
            state_d    = S_IDLE;
          end
        end
        S_CR:    state_d = S_LF;
        default: state_d = S_IDLE;
      endcase
    end

    // Char is latched on state entry so a clear cannot disturb a pending char.
    if (state_d != state_q) begin
      case (state_d)
        S_ADDR3: out_data_d = hex_char(offset_q[15:12]);
        S_ADDR2: out_data_d = hex_char(offset_q[11:8]);
        S_ADDR1: out_data_d = hex_char(offset_q[7:4]);
        S_ADDR0: out_data_d = hex_char(offset_q[3:0]);
        S_COLON: out_data_d = 8'h3A;
        S_SPC:   out_data_d = 8'h20;
        S_SEP:   out_data_d = 8'h20;
        S_HI:    out_data_d = hex_char(fifo_rd_dat[7:4]);
        S_LO:    out_data_d = hex_char(fifo_rd_dat[3:0]);
        S_CR:    out_data_d = 8'h0D;
        S_LF:    out_data_d = 8'h0A;
        default: out_data_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      out_data_q <= 8'h00;
      offset_q   <= 16'h0000;
      line_idx_q <= '0;
      overflow_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      offset_q   <= offset_d;
      line_idx_q <= line_idx_d;
      overflow_q <= overflow_d;
      abort_q    <= abort_d;
    end
  end

  assign out_req  = (state_q != S_IDLE);
  assign out_data = out_data_q;
  assign overflow = overflow_q;
  assign busy     = ~fifo_empty | (state_q != S_IDLE);

endmodule

// Generic synchronous FIFO with BRAM-style registered read.
// Latency: rd_dat valid 1 cycle after rd_req; rd_pop frees the head slot separately.
// Backpressure: writes while full are ignored; a same-cycle pop does not make room.
module sync_fifo #(
  parameter int ASIZE = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_req,
  input  logic             rd_pop,
  output logic [WIDTH-1:0] rd_dat,
  output logic             empty,
  output logic             full
);

  typedef logic [ASIZE:0] ptr_t;

  logic [WIDTH-1:0] mem [2**ASIZE];
  logic [WIDTH-1:0] rd_dat_q;
  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  logic             wr_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ASIZE] != rd_ptr_q[ASIZE]) &&
                 (wr_ptr_q[ASIZE-1:0] == rd_ptr_q[ASIZE-1:0]);
  assign wr_en = wr_vld & ~full;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en)  wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (rd_pop) rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)  mem[wr_ptr_q[ASIZE-1:0]] <= wr_dat;
    if (rd_req) rd_dat_q <= mem[rd_ptr_q[ASIZE-1:0]];
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: tb/tb_sector_hexdump.sv
// Bench for sector_hexdump: default instance plus a 16-byte-FIFO lowercase instance.
module tb_sector_hexdump;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] clear, in_valid, out_gnt, out_req, overflow, busy;
  logic [7:0] in_data  [2];
  logic [7:0] out_data [2];

  always #5 clk = ~clk;

  sector_hexdump u_dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear[0]), .in_valid(in_valid[0]),
    .in_data(in_data[0]), .out_req(out_req[0]), .out_gnt(out_gnt[0]),
    .out_data(out_data[0]), .overflow(overflow[0]), .busy(busy[0])
  );

  sector_hexdump #(.FIFO_ASIZE(4), .BYTES_PER_LINE(16), .UPPERCASE(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear[1]), .in_valid(in_valid[1]),
    .in_data(in_data[1]), .out_req(out_req[1]), .out_gnt(out_gnt[1]),
    .out_data(out_data[1]), .overflow(overflow[1]), .busy(busy[1])
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [7:0]  exp_q [2][$];
  logic [7:0]  rx_q  [2][$];
  logic [15:0] moff [2];
  int          midx [2];
  logic        pend_prev [2];
  logic [7:0]  pdat [2];
  bit          sec_done;

  typedef struct {
    int         inst;
    logic [7:0] first;
    int         n;
    bit         crlf;
    string      exp;
  } vec_t;
  vec_t vt [5];

  function automatic logic [7:0] hexc(input logic [3:0] n, input bit up);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (up ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic model_push(input int i, input logic [7:0] b);
    bit up = (i == 0);
    if (midx[i] == 0) begin
      exp_q[i].push_back(hexc(moff[i][15:12], up));
      exp_q[i].push_back(hexc(moff[i][11:8], up));
      exp_q[i].push_back(hexc(moff[i][7:4], up));
      exp_q[i].push_back(hexc(moff[i][3:0], up));
      exp_q[i].push_back(8'h3A);
      exp_q[i].push_back(8'h20);
    end else begin
      exp_q[i].push_back(8'h20);
    end
    exp_q[i].push_back(hexc(b[7:4], up));
    exp_q[i].push_back(hexc(b[3:0], up));
    if (midx[i] == 15) begin
      exp_q[i].push_back(8'h0D);
      exp_q[i].push_back(8'h0A);
      midx[i] = 0;
    end else begin
      midx[i]++;
    end
    moff[i] = moff[i] + 16'd1;
  endtask

  task automatic send(input int i, input logic [7:0] b, input bit push);
    in_valid[i] = 1'b1;
    in_data[i]  = b;
    if (push) model_push(i, b);
    tick();
    in_valid[i] = 1'b0;
  endtask

  // Only the char currently pending survives a clear.
  task automatic clear_dut(input int i);
    logic [7:0] keep;
    clear[i] = 1'b1;
    if (out_req[i] && exp_q[i].size() > 0) begin
      keep = exp_q[i][0];
      exp_q[i].delete();
      exp_q[i].push_back(keep);
    end else begin
      exp_q[i].delete();
    end
    moff[i] = 16'h0000;
    midx[i] = 0;
    tick();
    clear[i] = 1'b0;
  endtask

  task automatic drain(input int i, input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      if (exp_q[i].size() == 0 && !out_req[i] && !busy[i]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_drain: %0d chars outstanding, out_req=%b busy=%b, required 0/0/0",
               name, exp_q[i].size(), out_req[i], busy[i]);
    end
    repeat (8) tick();
    check({name, "_idle_req"}, 32'(out_req[i]), 32'd0);
  endtask

  task automatic wait_req(input int i, input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (out_req[i]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: out_req=0 after 200 cycles, required 1", name);
    end
  endtask

  task automatic check_rx(input int i, input string exp, input bit crlf, input string name);
    bit    ok;
    int    len;
    string act;
    len = exp.len() + (crlf ? 2 : 0);
    ok  = (rx_q[i].size() == len);
    for (int k = 0; ok && k < exp.len(); k++)
      if (rx_q[i][k] !== exp[k]) ok = 1'b0;
    if (ok && crlf)
      if (rx_q[i][len-2] !== 8'h0D || rx_q[i][len-1] !== 8'h0A) ok = 1'b0;
    n_chk++;
    if (!ok) begin
      n_fail++;
      act = "";
      for (int k = 0; k < rx_q[i].size() && k < 80; k++)
        act = $sformatf("%s%c", act,
                        (rx_q[i][k] >= 8'h20 && rx_q[i][k] < 8'h7F) ? rx_q[i][k] : 8'h2E);
      $display("FAIL %s: got %0d chars \"%s\", required %0d chars \"%s\"%s",
               name, rx_q[i].size(), act, len, exp, crlf ? " + CR LF" : "");
    end
  endtask

  // Scoreboard: every granted char is popped against the model's queue.
  always @(negedge clk) begin
    logic [7:0] e;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        pend_prev[i] = 1'b0;
      end else begin
        if (pend_prev[i]) begin
          n_chk++;
          if (!out_req[i] || out_data[i] !== pdat[i]) begin
            n_fail++;
            $display("FAIL hold%0d: out_req=%b out_data=%h, required out_req=1 out_data=%h",
                     i, out_req[i], out_data[i], pdat[i]);
          end
        end
        if (out_req[i] && out_gnt[i]) begin
          rx_q[i].push_back(out_data[i]);
          n_chk++;
          if (exp_q[i].size() == 0) begin
            n_fail++;
            $display("FAIL char%0d: got %h, required no character", i, out_data[i]);
          end else begin
            e = exp_q[i].pop_front();
            if (e !== out_data[i]) begin
              n_fail++;
              $display("FAIL char%0d: got %h, required %h", i, out_data[i], e);
            end
          end
        end
        pend_prev[i] = out_req[i] && !out_gnt[i];
        pdat[i]      = out_data[i];
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int    lf_cnt;
    string l31;

    vt[0] = '{0, 8'h00, 16, 1'b1, "0000: 00 01 02 03 04 05 06 07 08 09 0A 0B 0C 0D 0E 0F"};
    vt[1] = '{0, 8'hA5, 1,  1'b0, "0000: A5"};
    vt[2] = '{1, 8'hBC, 1,  1'b0, "0000: bc"};
    vt[3] = '{0, 8'hFE, 3,  1'b0, "0000: FE FF 00"};
    vt[4] = '{1, 8'h9A, 2,  1'b0, "0000: 9a 9b"};

    rst_n = 1'b0;
    clear = '0;
    in_valid = '0;
    out_gnt = '0;
    for (int i = 0; i < 2; i++) begin
      in_data[i] = 8'h00;
      moff[i] = 16'h0000;
      midx[i] = 0;
      pend_prev[i] = 1'b0;
      pdat[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_out_req%0d", i),  32'(out_req[i]),  32'd0);
      check($sformatf("rst_out_data%0d", i), 32'(out_data[i]), 32'd0);
      check($sformatf("rst_overflow%0d", i), 32'(overflow[i]), 32'd0);
      check($sformatf("rst_busy%0d", i),     32'(busy[i]),     32'd0);
    end
    rst_n = 1'b1;
    tick();
    tick();

    out_gnt = 2'b11;
    for (int v = 0; v < 5; v++) begin
      clear_dut(vt[v].inst);
      rx_q[vt[v].inst].delete();
      for (int k = 0; k < vt[v].n; k++)
        send(vt[v].inst, 8'(vt[v].first + 8'(k)), 1'b1);
      drain(vt[v].inst, $sformatf("vec%0d", v));
      check_rx(vt[v].inst, vt[v].exp, vt[v].crlf, $sformatf("vec%0d_text", v));
      check($sformatf("vec%0d_busy", v), 32'(busy[vt[v].inst]), 32'd0);
    end

    // Full sector, bursty input and ~30% grant rate.
    clear_dut(0);
    rx_q[0].delete();
    sec_done = 1'b0;
    fork
      begin
        bit ok = 1'b0;
        for (int k = 0; k < 512; k++) begin
          repeat ($urandom_range(0, 3)) tick();
          send(0, k[7:0], 1'b1);
        end
        for (int c = 0; c < 40000; c++) begin
          if (exp_q[0].size() == 0 && !out_req[0] && !busy[0]) begin
            ok = 1'b1;
            break;
          end
          tick();
        end
        check("sector_drained", 32'(ok), 32'd1);
        sec_done = 1'b1;
      end
      begin
        while (!sec_done) begin
          out_gnt[0] = ($urandom_range(0, 9) < 3);
          tick();
        end
      end
    join
    out_gnt[0] = 1'b1;
    lf_cnt = 0;
    foreach (rx_q[0][k]) if (rx_q[0][k] == 8'h0A) lf_cnt++;
    check("sector_chars", 32'(rx_q[0].size()), 32'd1760);
    check("sector_lines", 32'(lf_cnt), 32'd32);
    l31 = "";
    for (int k = 0; k < 8 && (31 * 55 + k) < rx_q[0].size(); k++)
      l31 = $sformatf("%s%c", l31, rx_q[0][31 * 55 + k]);
    n_chk++;
    if (l31 != "01F0: F0") begin
      n_fail++;
      $display("FAIL sector_line31: got \"%s\", required \"01F0: F0\"", l31);
    end
    check("sector_overflow", 32'(overflow[0]), 32'd0);

    // clear while a char is pending and ungranted; same-cycle byte is dropped.
    clear_dut(0);
    rx_q[0].delete();
    out_gnt[0] = 1'b0;
    for (int k = 0; k < 5; k++) send(0, 8'(8'h50 + 8'(k)), 1'b1);
    wait_req(0, "cm_req");
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h77;
    clear_dut(0);
    in_valid[0] = 1'b0;
    check("cm_req_held",  32'(out_req[0]),  32'd1);
    check("cm_data_held", 32'(out_data[0]), 32'h30);
    check("cm_overflow",  32'(overflow[0]), 32'd0);
    out_gnt[0] = 1'b1;
    drain(0, "cm_pending");
    send(0, 8'h11, 1'b1);
    drain(0, "cm");
    check_rx(0, "00000: 11", 1'b0, "cm_text");
    check("cm_overflow_end", 32'(overflow[0]), 32'd0);

    // Reset asserted while the HI char is pending.
    clear_dut(0);
    rx_q[0].delete();
    out_gnt[0] = 1'b0;
    send(0, 8'h5C, 1'b1);
    for (int k = 0; k < 6; k++) begin
      wait_req(0, "rm_req");
      out_gnt[0] = 1'b1;
      tick();
      out_gnt[0] = 1'b0;
    end
    check("rm_hi_req",  32'(out_req[0]),  32'd1);
    check("rm_hi_char", 32'(out_data[0]), 32'h35);
    #2 rst_n = 1'b0;
    #1;
    check("rm_async_req",  32'(out_req[0]),  32'd0);
    check("rm_async_data", 32'(out_data[0]), 32'd0);
    check("rm_async_busy", 32'(busy[0]),     32'd0);
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      moff[i] = 16'h0000;
      midx[i] = 0;
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    rx_q[0].delete();
    out_gnt[0] = 1'b1;
    send(0, 8'h22, 1'b1);
    drain(0, "rm");
    check_rx(0, "0000: 22", 1'b0, "rm_text");

    // Overflow on the 16-entry instance with the output stalled.
    clear_dut(1);
    rx_q[1].delete();
    out_gnt[1] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      send(1, 8'(8'hA0 + 8'(k)), k < 16);
      if (k == 15) check("ovf_after16", 32'(overflow[1]), 32'd0);
      if (k == 16) check("ovf_after17", 32'(overflow[1]), 32'd1);
    end
    out_gnt[1] = 1'b1;
    drain(1, "ovf");
    check_rx(1, "0000: a0 a1 a2 a3 a4 a5 a6 a7 a8 a9 aa ab ac ad ae af", 1'b1, "ovf_text");
    check("ovf_sticky", 32'(overflow[1]), 32'd1);
    clear_dut(1);
    check("ovf_cleared", 32'(overflow[1]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
